// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state codes, default
// frame geometry, parity-config bit positions and the parity check helper.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  // Bit positions inside the 2-bit parity configuration (shared with transmit).
  localparam int PAR_EN  = 0;
  localparam int PAR_ODD = 1;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t ST_IDLE   = 3'd0;
  localparam rx_state_t ST_START  = 3'd1;
  localparam rx_state_t ST_DATA   = 3'd2;
  localparam rx_state_t ST_PARITY = 3'd3;
  localparam rx_state_t ST_STOP   = 3'd4;

  // True when data parity combined with the received parity bit disagrees
  // with the selected sense (odd_sel=1: total number of ones must be odd).
  function automatic logic parity_mismatch(input logic data_xor,
                                           input logic par_bit,
                                           input logic odd_sel);
    return ((data_xor ^ par_bit) != odd_sel);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous serial line into the br domain and flags a
// high-to-low transition of the synchronised line. All flops idle high.
module uart_rx_sync (
  input  logic br,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Next-state for the two synchroniser stages and the one-cycle history flop.
  always_comb begin
    meta_d = rx;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchroniser and history flops; reset to the idle line level.
  always_ff @(posedge br or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rx_s    = sync_q;
  assign rx_fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_receive.sv
// UART receiver: validates the start bit at mid-bit, shifts in data bits
// LSB-first, optionally checks parity, checks the stop bit and presents the
// byte plus status flags to the host register block.
module uart_receive
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 br,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [1:0]           parity,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] rbr,
  output logic                 data_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy
);

  localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Start-bit check happens half a bit in; every later sample is one full
  // bit after the previous, so all samples land mid-bit.
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

  logic rx_s;
  logic rx_fall;

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           par_cfg_q, par_cfg_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] rbr_q, rbr_d;
  logic                 data_ready_q, data_ready_d;
  logic                 parity_error_q, parity_error_d;
  logic                 framing_error_q, framing_error_d;
  logic                 overrun_error_q, overrun_error_d;
  logic                 busy_q, busy_d;

  uart_rx_sync u_sync (
    .br      (br),
    .rst     (rst),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  // Frame FSM, bit timing, deserialiser and host-visible status update.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    par_cfg_d       = par_cfg_q;
    perr_d          = perr_q;
    rbr_d           = rbr_q;
    data_ready_d    = data_ready_q;
    parity_error_d  = parity_error_q;
    framing_error_d = framing_error_q;
    overrun_error_d = overrun_error_q;

    // A host read clears status; a load in STOP below overrides this.
    if (rd) begin
      data_ready_d    = 1'b0;
      parity_error_d  = 1'b0;
      framing_error_d = 1'b0;
      overrun_error_d = 1'b0;
    end else begin
      data_ready_d    = data_ready_q;
      parity_error_d  = parity_error_q;
      framing_error_d = framing_error_q;
      overrun_error_d = overrun_error_q;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Edge-triggered so a held-low line (break) starts only one frame.
        if (rx_fall) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            par_cfg_d = parity;
            bit_idx_d = '0;
            perr_d    = 1'b0;
            state_d   = ST_DATA;
          end else begin
            // Glitch shorter than half a bit: drop it silently.
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == IDX_LAST) begin
            if (par_cfg_q[PAR_EN]) begin
              state_d = ST_PARITY;
            end else begin
              state_d = ST_STOP;
            end
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_PARITY: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          perr_d  = parity_mismatch(^shift_q, rx_s, par_cfg_q[PAR_ODD]);
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d           = '0;
          rbr_d           = shift_q;
          data_ready_d    = 1'b1;
          parity_error_d  = perr_q;
          framing_error_d = ~rx_s;
          overrun_error_d = data_ready_q & ~rd;
          state_d         = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers; async reset abandons any partial frame.
  always_ff @(posedge br or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      par_cfg_q       <= 2'b00;
      perr_q          <= 1'b0;
      rbr_q           <= '0;
      data_ready_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_error_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      par_cfg_q       <= par_cfg_d;
      perr_q          <= perr_d;
      rbr_q           <= rbr_d;
      data_ready_q    <= data_ready_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
      overrun_error_q <= overrun_error_d;
      busy_q          <= busy_d;
    end
  end

  assign rbr           = rbr_q;
  assign data_ready    = data_ready_q;
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;
  assign overrun_error = overrun_error_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_receive.sv
// Self-checking bench for uart_receive: directed frames followed by random
// frames, each compared against a frame-level reference model.
module tb_uart_receive;

  localparam int OS = 16;

  logic       br = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd;
  logic [1:0] parity;
  logic [7:0] rbr;
  logic       data_ready;
  logic       parity_error;
  logic       framing_error;
  logic       overrun_error;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Free-running posedge counter and data_ready rise monitor.
  int   cyc = 0;
  int   rise_count = 0;
  int   rise_cyc = 0;
  logic dr_prev = 1'b0;

  // Reference model state.
  logic       exp_dr = 1'b0;
  logic [7:0] exp_rbr = 8'h00;
  logic       exp_pe = 1'b0;
  logic       exp_fe = 1'b0;
  logic       exp_oe = 1'b0;

  uart_receive #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .br            (br),
    .rst           (rst),
    .rx            (rx),
    .parity        (parity),
    .rd            (rd),
    .rbr           (rbr),
    .data_ready    (data_ready),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .overrun_error (overrun_error),
    .busy          (busy)
  );

  always #5 br = ~br;

  always @(posedge br) cyc <= cyc + 1;

  always @(negedge br) begin
    if (data_ready && !dr_prev) begin
      rise_count <= rise_count + 1;
      rise_cyc   <= cyc;
    end
    dr_prev <= data_ready;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ones_of(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return n;
  endfunction

  // Parity bit a correct transmitter would send.
  function automatic logic good_pbit(input logic [7:0] d, input logic odd);
    return logic'(ones_of(d) % 2) ^ odd;
  endfunction

  // Parity error: total ones over data+parity bit disagrees with the sense.
  function automatic logic ref_perr(input logic [7:0] d, input logic pen,
                                    input logic odd, input logic pbit);
    int total = ones_of(d) + int'(pbit);
    return pen && ((total % 2) != int'(odd));
  endfunction

  task automatic line_level(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge br);
      rx = lvl;
    end
  endtask

  // Drives one frame one br cycle at a time; k=0 is the start-bit fall.
  task automatic drive_frame(input logic [7:0] d, input logic pen, input logic odd,
                             input logic pbit, input logic stop, input int rd_at,
                             input int abort_k, input bit scramble, output int fall_cyc);
    logic [10:0] bits;
    int nbits;
    nbits = pen ? 11 : 10;
    bits = 11'h7FF;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (pen) begin
      bits[9]  = pbit;
      bits[10] = stop;
    end else begin
      bits[9] = stop;
    end
    @(negedge br);
    parity = {odd, pen};
    fall_cyc = cyc;
    for (int k = 0; k < nbits * OS; k++) begin
      if (k > 0) @(negedge br);
      rx = bits[k / OS];
      rd = (k == rd_at);
      if (scramble && k >= OS) parity = 2'($urandom_range(0, 3));
      if (k == abort_k) begin
        rst = 1'b1;
        rx  = 1'b1;
        rd  = 1'b0;
        break;
      end
    end
  endtask

  task automatic frame_check(input string tag, input logic [7:0] d, input logic pen,
                             input logic odd, input logic pbit, input logic stop,
                             input bit rd_hit, input bit scramble);
    int fall_cyc, rc0, lat_exp, rd_at;
    logic was_dr;
    lat_exp = 2 + OS / 2 + OS * (9 + int'(pen));
    rd_at   = rd_hit ? lat_exp : -1;
    was_dr  = exp_dr;
    exp_oe  = exp_dr & ~rd_hit;
    exp_pe  = ref_perr(d, pen, odd, pbit);
    exp_fe  = ~stop;
    exp_rbr = d;
    exp_dr  = 1'b1;
    rc0 = rise_count;
    drive_frame(d, pen, odd, pbit, stop, rd_at, -1, scramble, fall_cyc);
    #1;
    check({tag, ".rbr"}, 32'(rbr), 32'(exp_rbr));
    check({tag, ".data_ready"}, 32'(data_ready), 32'(exp_dr));
    check({tag, ".parity_error"}, 32'(parity_error), 32'(exp_pe));
    check({tag, ".framing_error"}, 32'(framing_error), 32'(exp_fe));
    check({tag, ".overrun_error"}, 32'(overrun_error), 32'(exp_oe));
    check({tag, ".busy"}, 32'(busy), 32'(0));
    if (!was_dr) begin
      check({tag, ".rises"}, 32'(rise_count), 32'(rc0 + 1));
      // Edge 0 is the first br edge after the fall; the load lands on edge lat_exp.
      check({tag, ".latency"}, 32'(rise_cyc - fall_cyc - 1), 32'(lat_exp));
    end
  endtask

  task automatic rd_pulse(input string tag);
    @(negedge br);
    rd = 1'b1;
    @(negedge br);
    rd = 1'b0;
    #1;
    exp_dr = 1'b0;
    exp_pe = 1'b0;
    exp_fe = 1'b0;
    exp_oe = 1'b0;
    check({tag, ".data_ready"}, 32'(data_ready), 32'(0));
    check({tag, ".flags"}, 32'({parity_error, framing_error, overrun_error}), 32'(0));
    check({tag, ".rbr_hold"}, 32'(rbr), 32'(exp_rbr));
  endtask

  initial begin : main
    int rc0;
    int fc;
    logic [7:0] d;
    logic pen, odd, pbit, stop;
    bit rd_hit;

    rst = 1'b1;
    rx = 1'b1;
    rd = 1'b0;
    parity = 2'b00;
    repeat (3) @(negedge br);
    #1;
    check("reset.rbr", 32'(rbr), 32'(0));
    check("reset.flags", 32'({data_ready, parity_error, framing_error, overrun_error}), 32'(0));
    check("reset.busy", 32'(busy), 32'(0));
    @(negedge br);
    rst = 1'b0;
    line_level(1'b1, 5);

    frame_check("a5_8n1", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    rd_pulse("a5_rd");
    frame_check("3c_even_ok", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    rd_pulse("3c_even_ok_rd");
    frame_check("3c_even_bad", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    rd_pulse("3c_even_bad_rd");
    frame_check("01_odd_ok", 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    rd_pulse("01_odd_rd");

    // Break: stop bit low, line held low, then released.
    frame_check("55_break", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rc0 = rise_count;
    line_level(1'b0, 40);
    line_level(1'b1, 40);
    #1;
    check("break.single_load", 32'(rise_count), 32'(rc0));
    check("break.busy", 32'(busy), 32'(0));
    check("break.framing", 32'(framing_error), 32'(1));
    check("break.rbr", 32'(rbr), 32'(8'h55));
    rd_pulse("break_rd");

    // Short low glitch: reaches START only.
    rc0 = rise_count;
    line_level(1'b0, 5);
    #1;
    check("glitch.busy_high", 32'(busy), 32'(1));
    line_level(1'b1, 30);
    #1;
    check("glitch.busy_low", 32'(busy), 32'(0));
    check("glitch.data_ready", 32'(data_ready), 32'(0));
    check("glitch.no_rise", 32'(rise_count), 32'(rc0));

    frame_check("b2b_11", 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    frame_check("b2b_22_overrun", 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    rd_pulse("b2b_rd");
    frame_check("b2b_11b", 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    frame_check("b2b_22_rdhit", 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    rd_pulse("b2b_rdhit_rd");

    // Async reset in the middle of data bit 4.
    frame_check("pre_rst_9b", 8'h9B, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, -1, OS * 5 + OS / 2, 1'b0, fc);
    #1;
    check("midrst.rbr", 32'(rbr), 32'(0));
    check("midrst.flags", 32'({data_ready, parity_error, framing_error, overrun_error}), 32'(0));
    check("midrst.busy", 32'(busy), 32'(0));
    @(negedge br);
    rst = 1'b0;
    exp_dr = 1'b0;
    exp_oe = 1'b0;
    line_level(1'b1, 5);
    frame_check("7e_after_rst", 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    rd_pulse("7e_rd");

    // Random frames, parity input scrambled after start-bit validation.
    for (int n = 0; n < 24; n++) begin
      d      = 8'($urandom_range(0, 255));
      pen    = 1'($urandom_range(0, 1));
      odd    = 1'($urandom_range(0, 1));
      pbit   = good_pbit(d, odd) ^ ($urandom_range(0, 3) == 0);
      stop   = ($urandom_range(0, 7) != 0);
      rd_hit = ($urandom_range(0, 3) == 0);
      frame_check("rand", d, pen, odd, pbit, stop, rd_hit, 1'b1);
      line_level(1'b1, $urandom_range(1, 20));
      if ($urandom_range(0, 2) == 0) rd_pulse("rand_rd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
